// File: rtl/pipe_reg_em_hs_if.sv
// EX->MEM stage handshake bundle: E-side valid/ready plus payload in,
// M-side valid/ready plus registered payload out.
// master : the producer/consumer environment around the stage
// slave  : the pipe_reg_em_hs stage itself
interface pipe_reg_em_hs_if #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int REG_W   = 5,
    parameter int INSTR_W = 32
);
    logic               valid_E;
    logic               ready_E;
    logic [INSTR_W-1:0] instr_E;
    logic [DATA_W-1:0]  data_alu_E;
    logic [DATA_W-1:0]  writedata_E;
    logic [REG_W-1:0]   writereg_E;
    logic [PC_W-1:0]    pcout_E;
    logic [PC_W-1:0]    pcchu_E;
    logic [DATA_W-1:0]  hilo_E;

    logic               valid_M;
    logic               ready_M;
    logic [INSTR_W-1:0] instr_M;
    logic [DATA_W-1:0]  data_alu_M;
    logic [DATA_W-1:0]  writedata_M;
    logic [REG_W-1:0]   writereg_M;
    logic [PC_W-1:0]    pcout_M;
    logic [PC_W-1:0]    pcchu_M;
    logic [DATA_W-1:0]  hilo_M;

    modport master (
        output valid_E, instr_E, data_alu_E, writedata_E, writereg_E,
               pcout_E, pcchu_E, hilo_E, ready_M,
        input  ready_E, valid_M, instr_M, data_alu_M, writedata_M,
               writereg_M, pcout_M, pcchu_M, hilo_M
    );

    modport slave (
        input  valid_E, instr_E, data_alu_E, writedata_E, writereg_E,
               pcout_E, pcchu_E, hilo_E, ready_M,
        output ready_E, valid_M, instr_M, data_alu_M, writedata_M,
               writereg_M, pcout_M, pcchu_M, hilo_M
    );
endinterface

// File: rtl/pipe_reg_em_hs.sv
// EX->MEM pipeline stage register with valid/ready handshake, flush and
// bubble insertion. A stalled M stage back-pressures E without losing or
// duplicating instructions; an empty stage presents an all-zero payload
// (instr_M = 0 is a NOP).
// Optional feature macro: PIPE_SKID_EN
//   defined   : 1-entry skid buffer, ready_E is registered (no ready_M->ready_E path)
//   undefined : no skid, ready_E = ~valid_M | ready_M (combinational)
module pipe_reg_em_hs #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int REG_W   = 5,
    parameter int INSTR_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_reg_em_hs_if.slave  bus
);
    localparam int PAY_W = INSTR_W + 3 * DATA_W + REG_W + 2 * PC_W;

    logic [PAY_W-1:0] pay_in_s;
    logic [PAY_W-1:0] pay_main_r;
    logic [PAY_W-1:0] pay_main_nxt_s;
    logic             valid_main_r;
    logic             valid_main_nxt_s;
    logic             accept_s;
    logic             load_s;

    assign pay_in_s = {bus.instr_E, bus.data_alu_E, bus.writedata_E, bus.writereg_E,
                       bus.pcout_E, bus.pcchu_E, bus.hilo_E};

    assign bus.valid_M = valid_main_r;
    assign {bus.instr_M, bus.data_alu_M, bus.writedata_M, bus.writereg_M,
            bus.pcout_M, bus.pcchu_M, bus.hilo_M} = pay_main_r;

    // Main register may take new contents when empty or being drained by M.
    assign load_s = ~valid_main_r | bus.ready_M;

`ifdef PIPE_SKID_EN
    logic [PAY_W-1:0] pay_skid_r;
    logic [PAY_W-1:0] pay_skid_nxt_s;
    logic             skid_full_r;
    logic             skid_full_nxt_s;
    logic             ready_r;

    assign bus.ready_E = ready_r;
    assign accept_s    = bus.valid_E & ready_r & ~flush;

    // Next-state for main and skid entries; skid always drains before new input.
    always_comb begin
        valid_main_nxt_s = valid_main_r;
        pay_main_nxt_s   = pay_main_r;
        skid_full_nxt_s  = skid_full_r;
        pay_skid_nxt_s   = pay_skid_r;
        if (flush) begin
            valid_main_nxt_s = 1'b0;
            pay_main_nxt_s   = {PAY_W{1'b0}};
            skid_full_nxt_s  = 1'b0;
            pay_skid_nxt_s   = {PAY_W{1'b0}};
        end else if (load_s) begin
            if (skid_full_r) begin
                // ready_E was low, so no input can be accepted alongside the drain
                valid_main_nxt_s = 1'b1;
                pay_main_nxt_s   = pay_skid_r;
                skid_full_nxt_s  = 1'b0;
                pay_skid_nxt_s   = {PAY_W{1'b0}};
            end else if (accept_s) begin
                valid_main_nxt_s = 1'b1;
                pay_main_nxt_s   = pay_in_s;
            end else begin
                valid_main_nxt_s = 1'b0;
                pay_main_nxt_s   = {PAY_W{1'b0}};
            end
        end else if (accept_s) begin
            // Main is holding for M: park the younger instruction in the skid
            skid_full_nxt_s = 1'b1;
            pay_skid_nxt_s  = pay_in_s;
        end else begin
            skid_full_nxt_s = skid_full_r;
        end
    end

    // Skid state and registered ready_E.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_full_r <= 1'b0;
            pay_skid_r  <= {PAY_W{1'b0}};
            ready_r     <= 1'b1;
        end else begin
            skid_full_r <= skid_full_nxt_s;
            pay_skid_r  <= pay_skid_nxt_s;
            ready_r     <= ~skid_full_nxt_s;
        end
    end
`else
    assign bus.ready_E = load_s;
    assign accept_s    = bus.valid_E & load_s & ~flush;

    // Next-state for the main register: load, bubble, or hold.
    always_comb begin
        valid_main_nxt_s = valid_main_r;
        pay_main_nxt_s   = pay_main_r;
        if (flush) begin
            valid_main_nxt_s = 1'b0;
            pay_main_nxt_s   = {PAY_W{1'b0}};
        end else if (accept_s) begin
            valid_main_nxt_s = 1'b1;
            pay_main_nxt_s   = pay_in_s;
        end else if (load_s) begin
            valid_main_nxt_s = 1'b0;
            pay_main_nxt_s   = {PAY_W{1'b0}};
        end else begin
            valid_main_nxt_s = valid_main_r;
        end
    end
`endif

    // Main stage register driving the M-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_main_r <= 1'b0;
            pay_main_r   <= {PAY_W{1'b0}};
        end else begin
            valid_main_r <= valid_main_nxt_s;
            pay_main_r   <= pay_main_nxt_s;
        end
    end
endmodule
